// File: rtl/eth_pkg.sv
// Shared Ethernet constants, CRC-32 parameters and framer state encoding.
// Used by the TX framer and the RX FCS checker.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE     = 3'd0;
    localparam tx_state_t ST_PREAMBLE = 3'd1;
    localparam tx_state_t ST_SFD      = 3'd2;
    localparam tx_state_t ST_DATA     = 3'd3;
    localparam tx_state_t ST_PAD      = 3'd4;
    localparam tx_state_t ST_FCS      = 3'd5;
    localparam tx_state_t ST_DRAIN    = 3'd6;
    localparam tx_state_t ST_IFG      = 3'd7;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_frame_tx_crc32_d8.sv
// Combinational byte-wide CRC-32 step (reflected, LSB of the byte first).
// Kept standalone so the RX FCS checker can reuse it.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ POLY_REFL;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/eth_frame_tx.sv
// GMII transmit framer: preamble/SFD, payload, zero padding, CRC-32 FCS and IFG.
// The state names the byte being prepared for the next cycle; all outputs except s_ready are registered.
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int IFG_LEN = 12
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       frame_done,
    output logic       abort
);

    localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_LEN);
    localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);
    localparam logic [15:0] PRE_LAST = 16'd7;

    tx_state_t   state, state_d;
    logic [10:0] byte_cnt, byte_cnt_d, cnt_inc;
    logic [15:0] aux_cnt, aux_cnt_d;
    logic [31:0] crc, crc_d, crc_seed, crc_next, fcs;
    logic [7:0]  crc_byte;
    logic [7:0]  tx_data_d;
    logic        tx_en_d, tx_er_d, abort_d;
    logic        done_pend, done_pend_d;
    logic        at_max;

    // Stop accepting once MAX_LEN bytes are in without s_last, so the overflow byte is left for DRAIN.
    assign at_max  = (byte_cnt == MAX_CNT);
    assign s_ready = (state == ST_SFD) || ((state == ST_DATA) && !at_max) || (state == ST_DRAIN);

    assign cnt_inc  = (state == ST_SFD) ? 11'd1 : byte_cnt + 11'd1;
    assign crc_seed = (state == ST_SFD) ? CRC32_INIT : crc;
    assign crc_byte = (state == ST_PAD) ? 8'h00 : s_data;
    assign fcs      = ~crc;

    crc32_d8 u_crc (
        .crc_in  (crc_seed),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d     = state;
        byte_cnt_d  = byte_cnt;
        aux_cnt_d   = aux_cnt;
        crc_d       = crc;
        tx_data_d   = 8'h00;
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        abort_d     = 1'b0;
        done_pend_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d   = ST_PREAMBLE;
                    aux_cnt_d = 16'd1;
                    tx_data_d = ETH_PREAMBLE;
                    tx_en_d   = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                if (aux_cnt == PRE_LAST) begin
                    state_d   = ST_SFD;
                    tx_data_d = ETH_SFD;
                end else begin
                    aux_cnt_d = aux_cnt + 16'd1;
                    tx_data_d = ETH_PREAMBLE;
                end
            end
            ST_SFD, ST_DATA: begin
                tx_en_d = 1'b1;
                if (s_valid && s_ready) begin
                    tx_data_d  = s_data;
                    crc_d      = crc_next;
                    byte_cnt_d = cnt_inc;
                    if (s_last) begin
                        aux_cnt_d = 16'd0;
                        state_d   = (cnt_inc >= MIN_CNT) ? ST_FCS : ST_PAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    tx_er_d = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_PAD: begin
                tx_en_d    = 1'b1;
                crc_d      = crc_next;
                byte_cnt_d = cnt_inc;
                if (cnt_inc >= MIN_CNT) begin
                    aux_cnt_d = 16'd0;
                    state_d   = ST_FCS;
                end
            end
            ST_FCS: begin
                tx_en_d   = 1'b1;
                tx_data_d = fcs[{aux_cnt[1:0], 3'b000} +: 8];
                aux_cnt_d = aux_cnt + 16'd1;
                if (aux_cnt[1:0] == 2'd3) begin
                    aux_cnt_d   = 16'd0;
                    done_pend_d = 1'b1;
                    state_d     = ST_IFG;
                end
            end
            ST_DRAIN: begin
                if (s_valid && s_last) begin
                    aux_cnt_d = 16'd0;
                    state_d   = ST_IFG;
                end
            end
            ST_IFG: begin
                if (aux_cnt == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    aux_cnt_d = aux_cnt + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // frame_done trails done_pend by one cycle so it lands after the last FCS byte leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_cnt   <= 11'd0;
            aux_cnt    <= 16'd0;
            crc        <= CRC32_INIT;
            tx_data    <= 8'h00;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            abort      <= 1'b0;
            done_pend  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            byte_cnt   <= byte_cnt_d;
            aux_cnt    <= aux_cnt_d;
            crc        <= crc_d;
            tx_data    <= tx_data_d;
            tx_en      <= tx_en_d;
            tx_er      <= tx_er_d;
            abort      <= abort_d;
            done_pend  <= done_pend_d;
            frame_done <= done_pend;
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Directed bench for eth_frame_tx: a default instance plus a MIN_LEN=0 instance sharing the input stream.
// A negedge monitor logs the selected instance's GMII side; each test task inspects that log.
module tb_eth_frame_tx;
    import eth_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_last;
    logic       sel_b;

    logic       s_ready_a, tx_en_a, tx_er_a, frame_done_a, abort_a;
    logic [7:0] tx_data_a;
    logic       s_ready_b, tx_en_b, tx_er_b, frame_done_b, abort_b;
    logic [7:0] tx_data_b;

    logic       m_ready, m_en, m_er, m_done, m_abort;
    logic [7:0] m_data;

    int n_cmp = 0;
    int n_bad = 0;
    bit send_ok;
    bit mon_on = 1'b0;

    logic [7:0] payload [0:1599];
    logic [7:0] q_data[$];
    logic       q_en[$], q_er[$], q_done[$], q_abort[$];

    always #5 clk = ~clk;

    eth_frame_tx dut_a (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready_a), .tx_data(tx_data_a), .tx_en(tx_en_a), .tx_er(tx_er_a),
        .frame_done(frame_done_a), .abort(abort_a)
    );

    eth_frame_tx #(.MIN_LEN(0)) dut_b (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready_b), .tx_data(tx_data_b), .tx_en(tx_en_b), .tx_er(tx_er_b),
        .frame_done(frame_done_b), .abort(abort_b)
    );

    assign m_ready = sel_b ? s_ready_b    : s_ready_a;
    assign m_data  = sel_b ? tx_data_b    : tx_data_a;
    assign m_en    = sel_b ? tx_en_b      : tx_en_a;
    assign m_er    = sel_b ? tx_er_b      : tx_er_a;
    assign m_done  = sel_b ? frame_done_b : frame_done_a;
    assign m_abort = sel_b ? abort_b      : abort_a;

    always @(negedge clk) begin
        if (mon_on) begin
            q_data.push_back(m_data);
            q_en.push_back(m_en);
            q_er.push_back(m_er);
            q_done.push_back(m_done);
            q_abort.push_back(m_abort);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_log();
        q_data.delete(); q_en.delete(); q_er.delete(); q_done.delete(); q_abort.delete();
    endtask

    function automatic logic [7:0] get_data(input int i);
        return (i >= 0 && i < q_data.size()) ? q_data[i] : 8'hEE;
    endfunction

    function automatic logic get_flag(input int sel, input int i);
        if (i < 0 || i >= q_en.size()) return 1'b0;
        case (sel)
            0: return q_en[i];
            1: return q_er[i];
            2: return q_done[i];
            default: return q_abort[i];
        endcase
    endfunction

    function automatic int count_flag(input int sel);
        int c = 0;
        for (int i = 0; i < q_en.size(); i++) if (get_flag(sel, i)) c++;
        return c;
    endfunction

    function automatic int first_en(input int from);
        if (from < 0) return -1;
        for (int i = from; i < q_en.size(); i++) if (q_en[i]) return i;
        return -1;
    endfunction

    function automatic int run_len(input int start);
        int n = 0;
        if (start < 0) return 0;
        while (start + n < q_en.size() && q_en[start + n]) n++;
        return n;
    endfunction

    function automatic int idle_nonzero();
        int c = 0;
        for (int i = 0; i < q_en.size(); i++) if (!q_en[i] && q_data[i] != 8'h00) c++;
        return c;
    endfunction

    // Running CRC over logged bytes, bit-reversed back to the normal (non-reflected) form.
    function automatic logic [31:0] residue(input int start, input int n);
        logic [31:0] c, r;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            b = get_data(start + k);
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ b[j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        for (int j = 0; j < 32; j++) r[j] = c[31-j];
        return r;
    endfunction

    task automatic send_frame(input int len, input int bubble_at);
        int idx = 0;
        int guard = 0;
        bit acc, bubbled;
        bubbled = 1'b0;
        s_valid = 1'b1; s_data = payload[0]; s_last = (len == 1);
        while (idx < len && guard < 3000) begin
            @(negedge clk);
            acc = s_valid && m_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) idx++;
            if (idx < len) begin
                if (idx == bubble_at && !bubbled && acc) begin
                    s_valid = 1'b0; bubbled = 1'b1;
                end else begin
                    s_valid = 1'b1; s_data = payload[idx]; s_last = (idx == len - 1);
                end
            end else begin
                s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
            end
        end
        send_ok = (idx == len);
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx_data_a, tx_en_a, tx_er_a, s_ready_a, frame_done_a, abort_a} !== 13'h0) begin
            n_bad++; $display("[TB] FAIL reset_a: got %h expected 0", {tx_data_a, tx_en_a, tx_er_a, s_ready_a, frame_done_a, abort_a});
        end
        n_cmp++;
        if ({tx_data_b, tx_en_b, tx_er_b, s_ready_b, frame_done_b, abort_b} !== 13'h0) begin
            n_bad++; $display("[TB] FAIL reset_b: got %h expected 0", {tx_data_b, tx_en_b, tx_er_b, s_ready_b, frame_done_b, abort_b});
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx_data_a, tx_en_a, s_ready_a} !== 10'h0) begin
            n_bad++; $display("[TB] FAIL idle_after_reset: got %h expected 0", {tx_data_a, tx_en_a, s_ready_a});
        end
    endtask

    task automatic test_check_vector();
        logic [7:0] exp [0:20];
        int s;
        for (int k = 0; k < 7; k++) exp[k] = 8'h55;
        exp[7] = 8'hD5;
        for (int k = 0; k < 9; k++) exp[8 + k] = 8'h31 + 8'(k);
        exp[17] = 8'h26; exp[18] = 8'h39; exp[19] = 8'hF4; exp[20] = 8'hCB;
        for (int k = 0; k < 9; k++) payload[k] = 8'h31 + 8'(k);
        sel_b = 1'b1;
        @(posedge clk); #1;
        clear_log();
        send_frame(9, -1);
        repeat (100) @(posedge clk);
        #1;
        s = first_en(0);
        n_cmp++;
        if (s !== 1) begin n_bad++; $display("[TB] FAIL chk_start: got %0d expected 1", s); end
        n_cmp++;
        if (run_len(s) !== 21) begin n_bad++; $display("[TB] FAIL chk_len: got %0d expected 21", run_len(s)); end
        for (int k = 0; k < 21; k++) begin
            n_cmp++;
            if (get_data(s + k) !== exp[k]) begin
                n_bad++; $display("[TB] FAIL chk_byte%0d: got %h expected %h", k, get_data(s + k), exp[k]);
            end
        end
        n_cmp++;
        if (count_flag(2) !== 1) begin n_bad++; $display("[TB] FAIL chk_done: got %0d expected 1", count_flag(2)); end
        n_cmp++;
        if (count_flag(1) !== 0) begin n_bad++; $display("[TB] FAIL chk_er: got %0d expected 0", count_flag(1)); end
        n_cmp++;
        if (idle_nonzero() !== 0) begin n_bad++; $display("[TB] FAIL chk_idle_data: got %0d expected 0", idle_nonzero()); end
        sel_b = 1'b0;
    endtask

    task automatic test_padding();
        logic [7:0] arp [0:13];
        int s, nz;
        arp[0] = 8'hFF; arp[1] = 8'hFF; arp[2] = 8'hFF; arp[3] = 8'hFF; arp[4] = 8'hFF; arp[5] = 8'hFF;
        arp[6] = 8'h02; arp[7] = 8'h00; arp[8] = 8'h00; arp[9] = 8'h00; arp[10] = 8'h00; arp[11] = 8'h01;
        arp[12] = 8'h08; arp[13] = 8'h06;
        for (int k = 0; k < 14; k++) payload[k] = arp[k];
        @(posedge clk); #1;
        clear_log();
        send_frame(14, -1);
        repeat (120) @(posedge clk);
        #1;
        s = first_en(0);
        n_cmp++;
        if (s !== 1) begin n_bad++; $display("[TB] FAIL pad_start: got %0d expected 1", s); end
        n_cmp++;
        if (run_len(s) !== 72) begin n_bad++; $display("[TB] FAIL pad_len: got %0d expected 72", run_len(s)); end
        for (int k = 0; k < 14; k++) begin
            n_cmp++;
            if (get_data(s + 8 + k) !== arp[k]) begin
                n_bad++; $display("[TB] FAIL pad_payload%0d: got %h expected %h", k, get_data(s + 8 + k), arp[k]);
            end
        end
        nz = 0;
        for (int k = 22; k < 68; k++) if (get_data(s + k) !== 8'h00) nz++;
        n_cmp++;
        if (nz !== 0) begin n_bad++; $display("[TB] FAIL pad_zeros: got %0d nonzero expected 0", nz); end
        n_cmp++;
        if (residue(s + 8, 64) !== 32'hC704DD7B) begin
            n_bad++; $display("[TB] FAIL pad_residue: got %h expected c704dd7b", residue(s + 8, 64));
        end
        n_cmp++;
        if (count_flag(2) !== 1) begin n_bad++; $display("[TB] FAIL pad_done: got %0d expected 1", count_flag(2)); end
    endtask

    task automatic test_back_to_back();
        int s1, l1, s2, l2;
        bit ok1;
        for (int k = 0; k < 64; k++) payload[k] = 8'(k * 3 + 1);
        @(posedge clk); #1;
        clear_log();
        send_frame(64, -1);
        ok1 = send_ok;
        send_frame(64, -1);
        repeat (120) @(posedge clk);
        #1;
        n_cmp++;
        if ((ok1 && send_ok) !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_send: got %0b%0b expected 11", ok1, send_ok); end
        s1 = first_en(0);
        l1 = run_len(s1);
        s2 = first_en(s1 + l1);
        l2 = run_len(s2);
        n_cmp++;
        if (l1 !== 76) begin n_bad++; $display("[TB] FAIL b2b_len1: got %0d expected 76", l1); end
        n_cmp++;
        if (s2 - (s1 + l1) !== 12) begin n_bad++; $display("[TB] FAIL b2b_gap: got %0d expected 12", s2 - (s1 + l1)); end
        n_cmp++;
        if (l2 !== 76) begin n_bad++; $display("[TB] FAIL b2b_len2: got %0d expected 76", l2); end
        n_cmp++;
        if ({get_data(s2), get_data(s2 + 7)} !== 16'h55D5) begin
            n_bad++; $display("[TB] FAIL b2b_preamble2: got %h expected 55d5", {get_data(s2), get_data(s2 + 7)});
        end
        n_cmp++;
        if (residue(s1 + 8, 68) !== CRC32_RESIDUE) begin n_bad++; $display("[TB] FAIL b2b_res1: got %h expected c704dd7b", residue(s1 + 8, 68)); end
        n_cmp++;
        if (residue(s2 + 8, 68) !== CRC32_RESIDUE) begin n_bad++; $display("[TB] FAIL b2b_res2: got %h expected c704dd7b", residue(s2 + 8, 68)); end
        n_cmp++;
        if (count_flag(2) !== 2) begin n_bad++; $display("[TB] FAIL b2b_done: got %0d expected 2", count_flag(2)); end
    endtask

    task automatic test_underrun();
        int s, l, bad;
        for (int k = 0; k < 40; k++) payload[k] = 8'(k) ^ 8'hA5;
        @(posedge clk); #1;
        clear_log();
        send_frame(40, 20);
        repeat (60) @(posedge clk);
        #1;
        s = first_en(0);
        l = run_len(s);
        n_cmp++;
        if (send_ok !== 1'b1) begin n_bad++; $display("[TB] FAIL urun_drain: got %0b expected 1", send_ok); end
        n_cmp++;
        if (l !== 29) begin n_bad++; $display("[TB] FAIL urun_len: got %0d expected 29", l); end
        n_cmp++;
        if ({get_flag(1, s + 28), get_flag(3, s + 28)} !== 2'b11) begin
            n_bad++; $display("[TB] FAIL urun_er_abort: got %b expected 11", {get_flag(1, s + 28), get_flag(3, s + 28)});
        end
        n_cmp++;
        if ({count_flag(1), count_flag(3), count_flag(2)} !== {32'd1, 32'd1, 32'd0}) begin
            n_bad++; $display("[TB] FAIL urun_counts: got er=%0d abort=%0d done=%0d expected 1 1 0", count_flag(1), count_flag(3), count_flag(2));
        end
        n_cmp++;
        if (first_en(s + l) !== -1) begin n_bad++; $display("[TB] FAIL urun_no_fcs: got %0d expected -1", first_en(s + l)); end
        bad = 0;
        for (int k = 0; k < 20; k++) if (get_data(s + 8 + k) !== payload[k]) bad++;
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("[TB] FAIL urun_data: got %0d wrong expected 0", bad); end
    endtask

    task automatic test_oversize();
        int s, l, bad;
        for (int k = 0; k < 1600; k++) payload[k] = 8'(k);
        @(posedge clk); #1;
        clear_log();
        send_frame(1600, -1);
        repeat (40) @(posedge clk);
        #1;
        s = first_en(0);
        l = run_len(s);
        n_cmp++;
        if (send_ok !== 1'b1) begin n_bad++; $display("[TB] FAIL big_drain: got %0b expected 1", send_ok); end
        n_cmp++;
        if (l !== 1523) begin n_bad++; $display("[TB] FAIL big_len: got %0d expected 1523", l); end
        n_cmp++;
        if ({get_flag(1, s + 1522), get_flag(3, s + 1522)} !== 2'b11) begin
            n_bad++; $display("[TB] FAIL big_er_abort: got %b expected 11", {get_flag(1, s + 1522), get_flag(3, s + 1522)});
        end
        n_cmp++;
        if ({count_flag(3), count_flag(2)} !== {32'd1, 32'd0}) begin
            n_bad++; $display("[TB] FAIL big_counts: got abort=%0d done=%0d expected 1 0", count_flag(3), count_flag(2));
        end
        bad = 0;
        for (int k = 0; k < 1514; k++) if (get_data(s + 8 + k) !== payload[k]) bad++;
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("[TB] FAIL big_data: got %0d wrong expected 0", bad); end
        n_cmp++;
        if (first_en(s + l) !== -1) begin n_bad++; $display("[TB] FAIL big_no_fcs: got %0d expected -1", first_en(s + l)); end
    endtask

    task automatic test_reset_mid_frame();
        int s;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx_en_a, s_ready_a} !== 2'b11) begin n_bad++; $display("[TB] FAIL mid_active: got %b expected 11", {tx_en_a, s_ready_a}); end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_en_a, tx_er_a, s_ready_a} !== 3'b000) begin
            n_bad++; $display("[TB] FAIL mid_rst: got %b expected 000", {tx_en_a, tx_er_a, s_ready_a});
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 9; k++) payload[k] = 8'h31 + 8'(k);
        @(posedge clk); #1;
        clear_log();
        send_frame(9, -1);
        repeat (120) @(posedge clk);
        #1;
        s = first_en(0);
        n_cmp++;
        if (s !== 1) begin n_bad++; $display("[TB] FAIL mid_restart: got %0d expected 1", s); end
        n_cmp++;
        if (run_len(s) !== 72) begin n_bad++; $display("[TB] FAIL mid_len: got %0d expected 72", run_len(s)); end
        n_cmp++;
        if ({get_data(s), get_data(s + 7), get_data(s + 8), get_data(s + 16)} !== 32'h55D53139) begin
            n_bad++; $display("[TB] FAIL mid_bytes: got %h expected 55d53139", {get_data(s), get_data(s + 7), get_data(s + 8), get_data(s + 16)});
        end
        n_cmp++;
        if (residue(s + 8, 64) !== CRC32_RESIDUE) begin n_bad++; $display("[TB] FAIL mid_residue: got %h expected c704dd7b", residue(s + 8, 64)); end
        n_cmp++;
        if (count_flag(2) !== 1) begin n_bad++; $display("[TB] FAIL mid_done: got %0d expected 1", count_flag(2)); end
    endtask

    initial begin
        test_reset();
        mon_on = 1'b1;
        test_check_vector();
        test_padding();
        test_back_to_back();
        test_underrun();
        test_oversize();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
